// File: rtl/rtc_write_sequencer.sv
// Write sequencer for the nine RTC time/date channels: strobes each enabled channel into
// the byte selector and writes its byte over a multiplexed address/data bus.
module rtc_write_sequencer #(
    parameter int unsigned T_PHASE   = 4,
    parameter logic [7:0]  BASE_ADDR = 8'h21
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [8:0] ch_en,
    input  logic [7:0] din,
    output logic [8:0] ch_sel,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       busy,
    output logic       done
);

    localparam int unsigned     CNT_W    = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_PHASE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_SETUP  = 3'd1,
        A_STROBE = 3'd2,
        A_HOLD   = 3'd3,
        D_SETUP  = 3'd4,
        D_STROBE = 3'd5,
        D_HOLD   = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [3:0]       idx_r;
    logic [3:0]       idx_nxt_s;
    logic [8:0]       mask_r;
    logic [8:0]       mask_nxt_s;
    logic [7:0]       data_r;
    logic [7:0]       data_nxt_s;
    logic [4:0]       scan_s;
    logic             phase_end_s;

    logic [8:0] ch_sel_r,  ch_sel_nxt_s;
    logic [7:0] ad_out_r,  ad_out_nxt_s;
    logic       ad_oe_r,   ad_oe_nxt_s;
    logic       cs_n_r,    cs_n_nxt_s;
    logic       ad_n_r,    ad_n_nxt_s;
    logic       wr_n_r,    wr_n_nxt_s;
    logic       rd_n_r;
    logic       busy_r,    busy_nxt_s;
    logic       done_r,    done_nxt_s;

    // Lowest set mask bit at or above 'from'; bit 4 of the result flags that one was found.
    function automatic logic [4:0] next_channel(input logic [8:0] mask, input logic [3:0] from);
        logic [4:0] res;
        res = 5'd0;
        for (int i = 8; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                res = {1'b1, 4'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign phase_end_s = (cnt_r == CNT_LAST);

    // Next-state, phase counter, channel index, latched mask and captured data byte.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        idx_nxt_s   = idx_r;
        mask_nxt_s  = mask_r;
        data_nxt_s  = data_r;
        scan_s      = 5'd0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (start) begin
                    mask_nxt_s = ch_en;
                    scan_s     = next_channel(ch_en, 4'd0);
                    if (scan_s[4]) begin
                        state_nxt_s = A_SETUP;
                        idx_nxt_s   = scan_s[3:0];
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            A_SETUP: begin
                if (phase_end_s) begin
                    state_nxt_s = A_STROBE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = A_SETUP;
                end
            end
            A_STROBE: begin
                if (phase_end_s) begin
                    state_nxt_s = A_HOLD;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = A_STROBE;
                end
            end
            A_HOLD: begin
                // The selector has seen ch_sel for the whole address phase by now.
                if (phase_end_s) begin
                    state_nxt_s = D_SETUP;
                    cnt_nxt_s   = CNT_ZERO;
                    data_nxt_s  = din;
                end else begin
                    state_nxt_s = A_HOLD;
                end
            end
            D_SETUP: begin
                if (phase_end_s) begin
                    state_nxt_s = D_STROBE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = D_SETUP;
                end
            end
            D_STROBE: begin
                if (phase_end_s) begin
                    state_nxt_s = D_HOLD;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = D_STROBE;
                end
            end
            D_HOLD: begin
                if (phase_end_s) begin
                    cnt_nxt_s = CNT_ZERO;
                    scan_s    = next_channel(mask_r, idx_r + 4'd1);
                    if (scan_s[4]) begin
                        state_nxt_s = A_SETUP;
                        idx_nxt_s   = scan_s[3:0];
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = D_HOLD;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
                idx_nxt_s   = 4'd0;
                mask_nxt_s  = 9'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered pins line up with the state.
    always_comb begin
        ch_sel_nxt_s = 9'd0;
        ad_out_nxt_s = 8'd0;
        ad_oe_nxt_s  = 1'b0;
        cs_n_nxt_s   = 1'b1;
        ad_n_nxt_s   = 1'b1;
        wr_n_nxt_s   = 1'b1;
        busy_nxt_s   = 1'b0;
        done_nxt_s   = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                busy_nxt_s = 1'b0;
            end
            A_SETUP, A_STROBE, A_HOLD: begin
                ch_sel_nxt_s = 9'd1 << idx_nxt_s;
                ad_out_nxt_s = BASE_ADDR + {4'd0, idx_nxt_s};
                ad_oe_nxt_s  = 1'b1;
                ad_n_nxt_s   = 1'b0;
                cs_n_nxt_s   = (state_nxt_s == A_SETUP);
                wr_n_nxt_s   = (state_nxt_s != A_STROBE);
                busy_nxt_s   = 1'b1;
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                ch_sel_nxt_s = 9'd1 << idx_nxt_s;
                ad_out_nxt_s = data_nxt_s;
                ad_oe_nxt_s  = 1'b1;
                ad_n_nxt_s   = 1'b1;
                cs_n_nxt_s   = (state_nxt_s == D_HOLD);
                wr_n_nxt_s   = (state_nxt_s != D_STROBE);
                busy_nxt_s   = 1'b1;
            end
            DONE: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset releases the bus and drops any burst in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            idx_r    <= 4'd0;
            mask_r   <= 9'd0;
            data_r   <= 8'd0;
            ch_sel_r <= 9'd0;
            ad_out_r <= 8'd0;
            ad_oe_r  <= 1'b0;
            cs_n_r   <= 1'b1;
            ad_n_r   <= 1'b1;
            wr_n_r   <= 1'b1;
            rd_n_r   <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            idx_r    <= idx_nxt_s;
            mask_r   <= mask_nxt_s;
            data_r   <= data_nxt_s;
            ch_sel_r <= ch_sel_nxt_s;
            ad_out_r <= ad_out_nxt_s;
            ad_oe_r  <= ad_oe_nxt_s;
            cs_n_r   <= cs_n_nxt_s;
            ad_n_r   <= ad_n_nxt_s;
            wr_n_r   <= wr_n_nxt_s;
            rd_n_r   <= 1'b1;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign ch_sel = ch_sel_r;
    assign ad_out = ad_out_r;
    assign ad_oe  = ad_oe_r;
    assign cs_n   = cs_n_r;
    assign ad_n   = ad_n_r;
    assign wr_n   = wr_n_r;
    assign rd_n   = rd_n_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Directed bench for rtc_write_sequencer with T_PHASE=4 and BASE_ADDR=8'h21.
module tb_rtc_write_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] ch_en = 9'd0;
    logic [7:0] din = 8'd0;
    logic [8:0] ch_sel;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, ad_n, wr_n, rd_n, busy, done;

    int errors = 0;
    int checks = 0;

    int b_cnt, done_at, done_cnt, wr_cnt, oe_cnt, cs_cnt, rd_bad, addr_bad, data_bad, sel_bad, lat;
    logic [8:0] sel_q[$];
    logic [8:0] wr_sel_q[$];
    logic [7:0] wr_ad_q[$];
    logic       wr_adn_q[$];
    int         wr_b_q[$];

    rtc_write_sequencer #(.T_PHASE(4), .BASE_ADDR(8'h21)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ch_en(ch_en), .din(din),
        .ch_sel(ch_sel), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .ad_n(ad_n),
        .wr_n(wr_n), .rd_n(rd_n), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sel_index(input logic [8:0] sel);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 9; i++) if (sel[i]) r = 8'(i);
        return r;
    endfunction

    // Issue one burst and record a per-cycle profile of the bus until busy falls.
    task automatic run_burst(input logic [8:0] en, input logic [7:0] d, input int chg_at,
                             input logic [7:0] d2, input int start_at);
        bit seen;
        bit timed_out;
        logic [8:0] last_sel;
        b_cnt = 0; done_at = 0; done_cnt = 0; wr_cnt = 0; oe_cnt = 0; cs_cnt = 0;
        rd_bad = 0; addr_bad = 0; data_bad = 0; sel_bad = 0; lat = 0;
        sel_q.delete(); wr_sel_q.delete(); wr_ad_q.delete(); wr_adn_q.delete(); wr_b_q.delete();
        seen = 1'b0; timed_out = 1'b1; last_sel = 9'd0;
        @(negedge clk); start = 1'b1; ch_en = en; din = d;
        @(negedge clk); start = 1'b0; ch_en = ~en;
        for (int c = 0; c < 2000; c++) begin
            if (busy) begin
                seen = 1'b1; b_cnt++;
                if (done) done_at = b_cnt;
            end else if (seen) begin
                timed_out = 1'b0;
                break;
            end else begin
                lat++;
            end
            if (done) done_cnt++;
            if (!wr_n) begin
                wr_cnt++; wr_sel_q.push_back(ch_sel); wr_ad_q.push_back(ad_out);
                wr_adn_q.push_back(ad_n); wr_b_q.push_back(b_cnt);
            end
            if (ad_oe) oe_cnt++;
            if (!cs_n) cs_cnt++;
            if (!rd_n) rd_bad++;
            if (ch_sel != 9'd0 && ch_sel != last_sel) sel_q.push_back(ch_sel);
            last_sel = ch_sel;
            if (ad_oe && !$onehot(ch_sel)) sel_bad++;
            if (ad_oe && !ad_n && ad_out !== 8'h21 + sel_index(ch_sel)) addr_bad++;
            if (ad_oe && ad_n && ad_out !== d) data_bad++;
            start = (start_at != 0 && b_cnt == start_at);
            if (chg_at != 0 && b_cnt == chg_at) din = d2;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (timed_out) begin errors++; $display("FAIL burst_timeout: busy never fell, en=%h", en); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; ch_en = 9'h1FF; din = 8'hFF;
        repeat (3) @(negedge clk);
        checks++; if (ch_sel !== 9'd0) begin errors++; $display("FAIL rst_ch_sel: got %h want 000", ch_sel); end
        checks++; if (ad_out !== 8'd0) begin errors++; $display("FAIL rst_ad_out: got %h want 00", ad_out); end
        checks++; if (ad_oe !== 1'b0) begin errors++; $display("FAIL rst_ad_oe: got %b want 0", ad_oe); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
        checks++; if (ad_n !== 1'b1) begin errors++; $display("FAIL rst_ad_n: got %b want 1", ad_n); end
        checks++; if (wr_n !== 1'b1) begin errors++; $display("FAIL rst_wr_n: got %b want 1", wr_n); end
        checks++; if (rd_n !== 1'b1) begin errors++; $display("FAIL rst_rd_n: got %b want 1", rd_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        start = 1'b0; ch_en = 9'd0; reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        run_burst(9'h001, 8'h45, 0, 8'h00, 0);
        checks++; if (lat > 1) begin errors++; $display("FAIL single_latency: got %0d want <=1", lat); end
        checks++; if (b_cnt !== 25) begin errors++; $display("FAIL single_busy_len: got %0d want 25", b_cnt); end
        checks++; if (done_cnt !== 1 || done_at !== 25) begin errors++; $display("FAIL single_done: count %0d at %0d want 1 at 25", done_cnt, done_at); end
        checks++; if (wr_cnt !== 8) begin errors++; $display("FAIL single_wr_cnt: got %0d want 8", wr_cnt); end
        checks++; if (wr_cnt == 8 && (wr_ad_q[0] !== 8'h21 || wr_adn_q[0] !== 1'b0 || wr_ad_q[3] !== 8'h21 || wr_adn_q[3] !== 1'b0))
            begin errors++; $display("FAIL single_addr_strobe: got %h/%b want 21/0", wr_ad_q[0], wr_adn_q[0]); end
        checks++; if (wr_cnt == 8 && (wr_ad_q[4] !== 8'h45 || wr_adn_q[4] !== 1'b1 || wr_ad_q[7] !== 8'h45 || wr_adn_q[7] !== 1'b1))
            begin errors++; $display("FAIL single_data_strobe: got %h/%b want 45/1", wr_ad_q[4], wr_adn_q[4]); end
        checks++; if (wr_cnt == 8 && (wr_b_q[0] !== 5 || wr_b_q[4] !== 17))
            begin errors++; $display("FAIL single_wr_position: got %0d,%0d want 5,17", wr_b_q[0], wr_b_q[4]); end
        checks++; if (wr_cnt == 8 && wr_sel_q[0] !== 9'h001) begin errors++; $display("FAIL single_ch_sel: got %h want 001", wr_sel_q[0]); end
        checks++; if (cs_cnt !== 16 || oe_cnt !== 24) begin errors++; $display("FAIL single_cs_oe: cs %0d oe %0d want 16 24", cs_cnt, oe_cnt); end
        checks++; if (rd_bad !== 0 || addr_bad !== 0 || data_bad !== 0 || sel_bad !== 0)
            begin errors++; $display("FAIL single_bus_values: rd %0d addr %0d data %0d sel %0d want 0", rd_bad, addr_bad, data_bad, sel_bad); end
    endtask

    task automatic test_multi();
        run_burst(9'h104, 8'h5A, 0, 8'h00, 0);
        checks++; if (b_cnt !== 49) begin errors++; $display("FAIL multi_busy_len: got %0d want 49", b_cnt); end
        checks++; if (sel_q.size() != 2 || sel_q[0] !== 9'h004 || sel_q[1] !== 9'h100)
            begin errors++; $display("FAIL multi_sel_order: got %0d sels first %h want 004,100", sel_q.size(), sel_q[0]); end
        checks++; if (wr_cnt !== 16) begin errors++; $display("FAIL multi_wr_cnt: got %0d want 16", wr_cnt); end
        checks++; if (wr_cnt == 16 && (wr_ad_q[0] !== 8'h23 || wr_ad_q[8] !== 8'h29 || wr_ad_q[12] !== 8'h5A))
            begin errors++; $display("FAIL multi_addrs: got %h,%h,%h want 23,29,5a", wr_ad_q[0], wr_ad_q[8], wr_ad_q[12]); end
        checks++; if (wr_cnt == 16 && wr_b_q[8] !== 29) begin errors++; $display("FAIL multi_no_gap: got %0d want 29", wr_b_q[8]); end
        checks++; if (addr_bad !== 0 || data_bad !== 0 || sel_bad !== 0 || done_at !== 49)
            begin errors++; $display("FAIL multi_bus_values: addr %0d data %0d sel %0d done_at %0d", addr_bad, data_bad, sel_bad, done_at); end
    endtask

    task automatic test_empty_mask();
        run_burst(9'h000, 8'h11, 0, 8'h00, 0);
        checks++; if (b_cnt !== 1 || done_cnt !== 1) begin errors++; $display("FAIL empty_busy_done: busy %0d done %0d want 1 1", b_cnt, done_cnt); end
        checks++; if (wr_cnt !== 0 || oe_cnt !== 0 || cs_cnt !== 0) begin errors++; $display("FAIL empty_bus_quiet: wr %0d oe %0d cs %0d want 0", wr_cnt, oe_cnt, cs_cnt); end
    endtask

    task automatic test_disturb();
        run_burst(9'h001, 8'h45, 18, 8'hA5, 10);
        checks++; if (data_bad !== 0) begin errors++; $display("FAIL disturb_data_hold: %0d bad data cycles want 0", data_bad); end
        checks++; if (wr_cnt == 8 && wr_ad_q[7] !== 8'h45) begin errors++; $display("FAIL disturb_data_value: got %h want 45", wr_ad_q[7]); end
        checks++; if (b_cnt !== 25 || done_cnt !== 1) begin errors++; $display("FAIL disturb_length: busy %0d done %0d want 25 1", b_cnt, done_cnt); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit got;
        @(negedge clk); start = 1'b1; ch_en = 9'h001; din = 8'h3C;
        @(negedge clk); start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!got) begin errors++; $display("FAIL b2b_first_done: done never seen"); end
        start = 1'b1; ch_en = 9'h002;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy got %b want 0", busy); end
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b1 || ch_sel !== 9'h002) begin errors++; $display("FAIL b2b_accept: busy %b sel %h want 1 002", busy, ch_sel); end
        n = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        checks++; if (n !== 25) begin errors++; $display("FAIL b2b_second_len: got %0d want 25", n); end
    endtask

    task automatic test_reset_mid_burst();
        bit found;
        @(negedge clk); start = 1'b1; ch_en = 9'h006; din = 8'h77;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (ch_sel == 9'h004 && !wr_n && ad_n) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL midrst_reach_dstrobe: channel 2 data strobe not seen"); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (wr_n !== 1'b1 || cs_n !== 1'b1 || ad_oe !== 1'b0)
            begin errors++; $display("FAIL midrst_bus_release: wr_n %b cs_n %b oe %b want 1 1 0", wr_n, cs_n, ad_oe); end
        checks++; if (ch_sel !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_state: sel %h busy %b want 000 0", ch_sel, busy); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle: busy got %b want 0", busy); end
        run_burst(9'h006, 8'h6B, 0, 8'h00, 0);
        checks++; if (sel_q.size() != 2 || sel_q[0] !== 9'h002) begin errors++; $display("FAIL midrst_restart_first: got %h want 002", sel_q[0]); end
        checks++; if (b_cnt !== 49 || data_bad !== 0) begin errors++; $display("FAIL midrst_restart_len: busy %0d data_bad %0d want 49 0", b_cnt, data_bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_empty_mask();
        test_disturb();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
